// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: stall vector
// layout, canned stall patterns and the controller state encoding.
package pipe_ctrl_pkg;

    localparam int STALL_W      = 6;
    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_WB     = 4;

    typedef logic [STALL_W-1:0] stall_vec_t;

    // Each pattern freezes a contiguous prefix of the pipe; bit 5 never set.
    localparam stall_vec_t STALL_NONE    = '0;
    localparam stall_vec_t STALL_FETCH   = stall_vec_t'((1 << STALL_PC) | (1 << STALL_IF_ID));
    localparam stall_vec_t STALL_LOADUSE = STALL_FETCH | stall_vec_t'(1 << STALL_ID_EX);
    localparam stall_vec_t STALL_MEM     = STALL_LOADUSE | stall_vec_t'((1 << STALL_EX_MEM) | (1 << STALL_WB));

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        FLUSH_PEND = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side view of the hazard controller: hazard inputs from ID/EX/MEM,
// stall/flush strobes back to the stage registers, and status counters.
interface pipeline_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    import pipe_ctrl_pkg::*;

    logic                 rs1_rd_en_id;
    logic                 rs2_rd_en_id;
    logic [4:0]           rs1_addr_id;
    logic [4:0]           rs2_addr_id;
    logic                 mem_read_ex;
    logic [4:0]           rd_addr_ex;
    logic                 branch_taken_ex;
    logic                 dmem_req_mem;
    logic                 dmem_ready;
    logic                 imem_ready;
    stall_vec_t           stall;
    logic                 flush_if_id;
    logic                 flush_id_ex;
    logic                 mem_timeout_err;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] loaduse_cnt;

    modport master (
        output rs1_rd_en_id, rs2_rd_en_id, rs1_addr_id, rs2_addr_id,
               mem_read_ex, rd_addr_ex, branch_taken_ex,
               dmem_req_mem, dmem_ready, imem_ready,
        input  stall, flush_if_id, flush_id_ex, mem_timeout_err,
               stall_cycles, loaduse_cnt
    );

    modport slave (
        input  rs1_rd_en_id, rs2_rd_en_id, rs1_addr_id, rs2_addr_id,
               mem_read_ex, rd_addr_ex, branch_taken_ex,
               dmem_req_mem, dmem_ready, imem_ready,
        output stall, flush_if_id, flush_id_ex, mem_timeout_err,
               stall_cycles, loaduse_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter. clear restarts the count; an inc in the same cycle
// is counted, so the value after a clear+inc edge is 1.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= WIDTH'(inc);
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the 5-stage RV32I pipeline: load-use
// bubbles, dmem wait freeze, deferred branch flush and stall statistics.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_WIDTH    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    pipeline_ctrl_if.slave  bus
);

    ctrl_state_t         state, state_nx;
    logic                pend_flush, pend_nx;
    logic                load_use, mem_wait;
    stall_vec_t          stall_c;
    logic                flush_if_id_c, flush_id_ex_c, lu_bubble;
    logic [TO_WIDTH-1:0] wait_cnt;
    logic                timeout_err;

    assign load_use = bus.mem_read_ex && (bus.rd_addr_ex != 5'd0) &&
                      ((bus.rs1_rd_en_id && (bus.rs1_addr_id == bus.rd_addr_ex)) ||
                       (bus.rs2_rd_en_id && (bus.rs2_addr_id == bus.rd_addr_ex)));
    // A ready without a request is meaningless and must not release anything.
    assign mem_wait = bus.dmem_req_mem && !bus.dmem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            pend_flush <= 1'b0;
        end else begin
            state      <= state_nx;
            pend_flush <= pend_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pend_nx  = pend_flush;
        case (state)
            RUN: begin
                if (mem_wait) begin
                    state_nx = MEM_WAIT;
                    pend_nx  = bus.branch_taken_ex;
                end else begin
                    pend_nx  = 1'b0;
                end
            end
            MEM_WAIT: begin
                if (mem_wait)        pend_nx  = pend_flush | bus.branch_taken_ex;
                else if (pend_flush) state_nx = FLUSH_PEND;
                else                 state_nx = RUN;
            end
            FLUSH_PEND: begin
                if (mem_wait) begin
                    state_nx = MEM_WAIT;
                end else begin
                    state_nx = RUN;
                    pend_nx  = 1'b0;
                end
            end
            default: begin
                state_nx = RUN;
                pend_nx  = 1'b0;
            end
        endcase
    end

    // Strobes are combinational, so reset has to mask them directly to read 0
    // while rst_n is held with live hazard inputs.
    always_comb begin
        stall_c       = STALL_NONE;
        flush_if_id_c = 1'b0;
        flush_id_ex_c = 1'b0;
        lu_bubble     = 1'b0;
        if (!rst_n) begin
            stall_c = STALL_NONE;
        end else if (mem_wait) begin
            stall_c = STALL_MEM;
        end else if (state == FLUSH_PEND || bus.branch_taken_ex) begin
            flush_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
        end else if (load_use) begin
            stall_c       = STALL_LOADUSE;
            flush_id_ex_c = 1'b1;
            lu_bubble     = 1'b1;
        end else if (!bus.imem_ready) begin
            stall_c       = STALL_FETCH;
            flush_id_ex_c = 1'b1;
        end
    end

    assign bus.stall       = stall_c;
    assign bus.flush_if_id = flush_if_id_c;
    assign bus.flush_id_ex = flush_id_ex_c;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .inc   (stall_c != STALL_NONE),
        .count (bus.stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_loaduse_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .inc   (lu_bubble),
        .count (bus.loaduse_cnt)
    );

    // Outside MEM_WAIT the count restarts, so it holds the number of wait
    // cycles already elapsed before the current one.
    sat_counter #(.WIDTH(TO_WIDTH)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state != MEM_WAIT),
        .inc   (mem_wait),
        .count (wait_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (state == MEM_WAIT && mem_wait && wait_cnt == TO_WIDTH'(MEM_TIMEOUT)) begin
            timeout_err <= 1'b1;
        end
    end

    assign bus.mem_timeout_err = timeout_err;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: table of single-cycle hazard vectors plus
// hand-written sequences for dmem waits, deferred flush, timeout and reset.
module tb_pipeline_ctrl;
    import pipe_ctrl_pkg::*;

    typedef struct {
        logic       r1en;
        logic [4:0] r1;
        logic       r2en;
        logic [4:0] r2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
        logic       imem;
        logic [5:0] stall;
        logic       fif;
        logic       fix;
        logic       lu;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   exp_sc;
    int   exp_lu;

    pipeline_ctrl_if #(.CNT_WIDTH(32)) bus ();

    pipeline_ctrl #(.CNT_WIDTH(32), .MEM_TIMEOUT(4), .TO_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic r1en, input logic [4:0] r1,
                                input logic r2en, input logic [4:0] r2,
                                input logic mr, input logic [4:0] rd, input logic br,
                                input logic req, input logic rdy, input logic imem,
                                input logic [5:0] stall, input logic fif,
                                input logic fix, input logic lu);
        vec_t v;
        v.r1en = r1en; v.r1 = r1; v.r2en = r2en; v.r2 = r2;
        v.mr = mr; v.rd = rd; v.br = br; v.req = req; v.rdy = rdy; v.imem = imem;
        v.stall = stall; v.fif = fif; v.fix = fix; v.lu = lu;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.rs1_rd_en_id    = v.r1en;
        bus.rs1_addr_id     = v.r1;
        bus.rs2_rd_en_id    = v.r2en;
        bus.rs2_addr_id     = v.r2;
        bus.mem_read_ex     = v.mr;
        bus.rd_addr_ex      = v.rd;
        bus.branch_taken_ex = v.br;
        bus.dmem_req_mem    = v.req;
        bus.dmem_ready      = v.rdy;
        bus.imem_ready      = v.imem;
    endtask

    // Drive one cycle, check strobes mid-cycle, then advance past the edge.
    task automatic cycle(input string nm, input vec_t v);
        drive(v);
        @(negedge clk);
        chk({nm, ".stall"}, 32'(bus.stall), 32'(v.stall));
        chk({nm, ".flush_if_id"}, 32'(bus.flush_if_id), 32'(v.fif));
        chk({nm, ".flush_id_ex"}, 32'(bus.flush_id_ex), 32'(v.fix));
        if (v.stall != 6'b0) exp_sc++;
        if (v.lu) exp_lu++;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[14];
    vec_t idle, fl, w, wb, wlu, rel, fetch;

    initial begin
        n_chk = 0; n_err = 0; exp_sc = 0; exp_lu = 0;

        //             r1en r1   r2en r2   mr rd   br req rdy im  stall      fif fix lu
        tbl[0]  = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 6'b000000, 0, 0, 0);
        tbl[1]  = mk(1, 5'd5, 0, 5'd0, 1, 5'd5, 0, 0, 0, 1, 6'b000111, 0, 1, 1);
        tbl[2]  = mk(1, 5'd0, 0, 5'd0, 1, 5'd0, 0, 0, 0, 1, 6'b000000, 0, 0, 0);
        tbl[3]  = mk(0, 5'd0, 1, 5'd7, 1, 5'd7, 0, 0, 0, 1, 6'b000111, 0, 1, 1);
        tbl[4]  = mk(0, 5'd5, 0, 5'd5, 1, 5'd5, 0, 0, 0, 1, 6'b000000, 0, 0, 0);
        tbl[5]  = mk(1, 5'd5, 0, 5'd0, 0, 5'd5, 0, 0, 0, 1, 6'b000000, 0, 0, 0);
        tbl[6]  = mk(1, 5'd5, 0, 5'd0, 1, 5'd5, 1, 0, 0, 1, 6'b000000, 1, 1, 0);
        tbl[7]  = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 6'b000011, 0, 1, 0);
        tbl[8]  = mk(1, 5'd5, 0, 5'd0, 1, 5'd5, 0, 0, 0, 0, 6'b000111, 0, 1, 1);
        tbl[9]  = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 6'b000000, 1, 1, 0);
        tbl[10] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 6'b000000, 0, 0, 0);
        tbl[11] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 1, 6'b000000, 0, 0, 0);
        tbl[12] = mk(1, 5'd3, 1, 5'd9, 1, 5'd9, 0, 0, 0, 1, 6'b000111, 0, 1, 1);
        tbl[13] = mk(1, 5'd9, 0, 5'd0, 1, 5'd6, 0, 0, 0, 1, 6'b000000, 0, 0, 0);

        idle  = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 6'b000000, 0, 0, 0);
        fl    = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 6'b000000, 1, 1, 0);
        w     = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1, 6'b011111, 0, 0, 0);
        wb    = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 1, 6'b011111, 0, 0, 0);
        wlu   = mk(1, 5'd5, 0, 5'd0, 1, 5'd5, 0, 1, 0, 1, 6'b011111, 0, 0, 0);
        rel   = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 1, 6'b000000, 0, 0, 0);
        fetch = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 6'b000011, 0, 1, 0);

        // Reset state
        rst_n = 1'b0;
        drive(idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.stall", 32'(bus.stall), 32'd0);
        chk("rst.flush_if_id", 32'(bus.flush_if_id), 32'd0);
        chk("rst.flush_id_ex", 32'(bus.flush_id_ex), 32'd0);
        chk("rst.timeout_err", 32'(bus.mem_timeout_err), 32'd0);
        chk("rst.stall_cycles", bus.stall_cycles, 32'd0);
        chk("rst.loaduse_cnt", bus.loaduse_cnt, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) cycle($sformatf("tbl%0d", i), tbl[i]);
        chk("tbl.loaduse_cnt", bus.loaduse_cnt, 32'(exp_lu));
        chk("tbl.stall_cycles", bus.stall_cycles, 32'(exp_sc));

        // Three-cycle dmem wait; a load-use during the freeze is not a bubble
        cycle("wait3.c1", w);
        cycle("wait3.c2", wlu);
        cycle("wait3.c3", w);
        cycle("wait3.rel", rel);
        cycle("wait3.after", idle);
        chk("wait3.stall_cycles", bus.stall_cycles, 32'(exp_sc));
        chk("wait3.loaduse_cnt", bus.loaduse_cnt, 32'(exp_lu));

        // Branch during a wait is deferred until after release
        cycle("defer.c1", wb);
        cycle("defer.c2", w);
        cycle("defer.exit", idle);
        cycle("defer.flush", fl);
        cycle("defer.run", idle);

        cycle("fetch.c1", fetch);
        cycle("fetch.c2", fetch);
        chk("fetch.stall_cycles", bus.stall_cycles, 32'(exp_sc));

        // Timeout: error visible after the wait counter reached 4 mid-wait
        chk("to.pre", 32'(bus.mem_timeout_err), 32'd0);
        for (int i = 0; i < 6; i++) begin
            cycle($sformatf("to.w%0d", i), w);
            chk($sformatf("to.err%0d", i), 32'(bus.mem_timeout_err), (i >= 4) ? 32'd1 : 32'd0);
        end
        cycle("to.rel", idle);
        chk("to.sticky1", 32'(bus.mem_timeout_err), 32'd1);
        cycle("to.idle", idle);
        chk("to.sticky2", 32'(bus.mem_timeout_err), 32'd1);

        // Reset mid-wait with a branch pending
        cycle("rstw.c1", wb);
        drive(w);
        rst_n = 1'b0;
        #1;
        chk("rstw.stall", 32'(bus.stall), 32'd0);
        chk("rstw.flush_if_id", 32'(bus.flush_if_id), 32'd0);
        chk("rstw.flush_id_ex", 32'(bus.flush_id_ex), 32'd0);
        chk("rstw.timeout_err", 32'(bus.mem_timeout_err), 32'd0);
        chk("rstw.stall_cycles", bus.stall_cycles, 32'd0);
        chk("rstw.loaduse_cnt", bus.loaduse_cnt, 32'd0);
        exp_sc = 0;
        exp_lu = 0;
        drive(idle);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle("rstw.run1", idle);
        cycle("rstw.run2", idle);
        cycle("rstw.lu", tbl[1]);
        chk("rstw.loaduse_after", bus.loaduse_cnt, 32'(exp_lu));
        chk("rstw.stall_after", bus.stall_cycles, 32'(exp_sc));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and stall controller for the 5-stage RV32I pipeline.
- Produces the 6-bit stall vector consumed by the inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Produces the flush (bubble) strobes for IF/ID and ID/EX.
- Detects load-use hazards from ID/EX register contents, sequences multi-cycle data-memory waits via a req/ready handshake, defers branch flushes that arrive during a freeze, and keeps stall performance counters.

Parameters:
- CNT_WIDTH, 32, width of the performance counters.
- MEM_TIMEOUT, 255, maximum consecutive dmem wait cycles before the sticky error flag sets.
- TO_WIDTH, 8, width of the wait-cycle counter; must satisfy 2^TO_WIDTH > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_rd_en_id  in  1  ID stage reads rs1.
- rs2_rd_en_id  in  1  ID stage reads rs2.
- rs1_addr_id  in  5  ID rs1 address.
- rs2_addr_id  in  5  ID rs2 address.
- mem_read_ex  in  1  instruction in EX is a load (ID/EX output).
- rd_addr_ex  in  5  EX destination register (ID/EX output).
- branch_taken_ex  in  1  EX resolved a taken branch or jump.
- dmem_req_mem  in  1  MEM stage issues a data-memory access.
- dmem_ready  in  1  data memory completes the access this cycle.
- imem_ready  in  1  instruction fetch data valid this cycle.
- stall  out  6  stall vector; bit 0 PC, bit 1 IF/ID, bit 2 ID/EX, bit 3 EX/MEM, bit 4 MEM/WB, bit 5 reserved, always 0.
- flush_if_id  out  1  load a NOP into IF/ID at the next edge.
- flush_id_ex  out  1  load a NOP (all control bits zero) into ID/EX at the next edge.
- mem_timeout_err  out  1  sticky; set when a dmem wait exceeds MEM_TIMEOUT.
- stall_cycles  out  CNT_WIDTH  count of cycles with any stall bit set.
- loaduse_cnt  out  CNT_WIDTH  count of load-use bubbles inserted.

Behaviour:
- Reset (rst_n low, asynchronous): FSM returns to RUN; all counters and flags clear; stall=6'b0, flush_if_id=0, flush_id_ex=0, mem_timeout_err=0, stall_cycles=0, loaduse_cnt=0. Reset mid-wait aborts the wait and drops any pending flush.
- Decode terms:
  - load_use = mem_read_ex && rd_addr_ex!=0 && ((rs1_rd_en_id && rs1_addr_id==rd_addr_ex) || (rs2_rd_en_id && rs2_addr_id==rd_addr_ex)).
  - mem_wait = dmem_req_mem && !dmem_ready.
- stall, flush_if_id and flush_id_ex are combinational from inputs and current state, with zero-cycle latency. All other state is registered.
- FSM states: RUN, MEM_WAIT, FLUSH_PEND.
- Output priority, evaluated every cycle, first match wins:
  1. mem_wait: stall=6'b011111; no flushes.
  2. state==FLUSH_PEND: flush_if_id=1, flush_id_ex=1, stall=0.
  3. branch_taken_ex: flush_if_id=1, flush_id_ex=1, stall=0. The branch overrides load-use because the ID instruction is discarded.
  4. load_use: stall=6'b000111, flush_id_ex=1, loaduse_cnt+1.
  5. !imem_ready: stall=6'b000011, flush_id_ex=1.
  6. Otherwise: all outputs 0.
- Transitions:
  - RUN -> MEM_WAIT on mem_wait. If branch_taken_ex is also high, set the pend_flush flag.
  - MEM_WAIT stays while mem_wait; pend_flush |= branch_taken_ex.
  - MEM_WAIT -> FLUSH_PEND when !mem_wait && pend_flush.
  - MEM_WAIT -> RUN when !mem_wait && !pend_flush. The exit cycle applies normal priorities 3-6.
  - FLUSH_PEND -> RUN after exactly 1 cycle; pend_flush clears. If mem_wait is high in FLUSH_PEND, go to MEM_WAIT and keep pend_flush.
- Wait counter: clears on entry to MEM_WAIT and increments each cycle mem_wait holds, saturating at all-ones. When wait_cnt==MEM_TIMEOUT while mem_wait is still high, mem_timeout_err sets and holds until reset. The stall continues; there is no recovery action.
- stall_cycles increments when stall!=0 and saturates at all-ones. loaduse_cnt saturates the same way.
- dmem_ready high without dmem_req_mem is ignored.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - stall vector bit indices (STALL_PC..STALL_WB);
  - constants STALL_NONE, STALL_FETCH=6'b000011, STALL_LOADUSE=6'b000111, STALL_MEM=6'b011111;
  - enum ctrl_state_t {RUN, MEM_WAIT, FLUSH_PEND}.
- Sub-module: sat_counter (parameterised width, inc, clear).
  - Instantiated for stall_cycles, loaduse_cnt and wait_cnt.
  - Hazard decode stays inline.

Test Plan:
- Load-use: mem_read_ex=1, rd_addr_ex=5, rs1_rd_en_id=1, rs1_addr_id=5 for 1 cycle -> stall=6'b000111, flush_id_ex=1, loaduse_cnt 0->1. Same with rd_addr_ex=0 -> stall=0, no flush.
- Dmem wait: dmem_req_mem=1, dmem_ready=0 for 3 cycles, then ready=1 -> stall=6'b011111 for exactly 3 cycles, 0 on the 4th; stall_cycles=3.
- Deferred branch: branch_taken_ex=1 in the first wait cycle of a 2-cycle dmem wait -> no flush during the wait; one cycle with flush_if_id=flush_id_ex=1 after release; then RUN.
- Simultaneous branch and load-use (no mem wait) -> flush_if_id=1, flush_id_ex=1, stall=0, loaduse_cnt unchanged.
- Timeout: with MEM_TIMEOUT=4, hold mem_wait for 6 cycles -> mem_timeout_err rises on the cycle wait_cnt reaches 4 and stays high after ready. Assert rst_n=0 mid-wait -> all outputs 0 immediately and FSM returns to RUN.
- Fetch wait: imem_ready=0 for 2 cycles -> stall=6'b000011, flush_id_ex=1 on both cycles.
